// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: shared MMIO offsets, window base and byte-lane merge helper
package dm_responder_pkg;
  localparam logic [1:0] OFF_COUNT   = 2'd0;
  localparam logic [1:0] OFF_COMPARE = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_LED     = 2'd3;
  localparam logic [15:0] MMIO_BASE_DEF = 16'hBFD0;
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] wen);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = wen[i] ? new_v[8*i+:8] : old_v[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/dm_timer.sv
// dm_timer: free-running COUNT, byte-writable COMPARE and sticky W1C pending flag
module dm_timer
  import dm_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  off,
  input  logic [3:0]  wen,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);
  logic [31:0] count_d, compare_d;
  logic        pending_d;
  // a software write to COUNT takes the place of that cycle's increment; a match beats a same-cycle clear
  always_comb begin
    count_d   = (sel && off == OFF_COUNT && |wen) ? merge(count, wdata, wen) : count + 32'd1;
    compare_d = (sel && off == OFF_COMPARE) ? merge(compare, wdata, wen) : compare;
    pending_d = (compare != 32'd0 && count == compare) ||
                (pending && !(sel && off == OFF_STATUS && wen[0] && wdata[0]));
  end
  // timer state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count   <= '0;
      compare <= '0;
      pending <= 1'b0;
    end else begin
      count   <= count_d;
      compare <= compare_d;
      pending <= pending_d;
    end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: data RAM plus timer/LED device window with unmapped-access detection
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          RAM_AW    = 10,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic [15:0] led,
  output logic        timer_irq,
  output logic        bad_access
);
  logic [31:0] mem [2**RAM_AW];
  logic [RAM_AW-1:0] word;
  logic [1:0]  off;
  logic        ram_hit, mmio_hit, unmapped, bad_d;
  logic [31:0] count, compare, ram_rd, cnt_rd, cmp_rd, led_mrg, mmio_rd, rdata_d;
  logic        pending;
  logic [29:0] prev_addr;
  logic        prev_unmapped;
  logic        unused_bits;
  assign unused_bits = ^{dm_addr[1:0], led_mrg[31:16]};
  assign word      = dm_addr[RAM_AW+1:2];
  assign off       = dm_addr[3:2];
  assign timer_irq = pending;
  dm_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .sel     (mmio_hit),
    .off     (off),
    .wen     (dm_wen),
    .wdata   (dm_wdata),
    .count   (count),
    .compare (compare),
    .pending (pending)
  );
  // decode and read mux; a register written this cycle reads back its merged value
  always_comb begin
    ram_hit  = dm_addr[31:RAM_AW+2] == '0;
    mmio_hit = dm_addr[31:16] == MMIO_BASE && dm_addr[15:4] == 12'h000;
    unmapped = !ram_hit && !mmio_hit;
    ram_rd   = merge(mem[word], dm_wdata, dm_wen);
    cnt_rd   = merge(count, dm_wdata, dm_wen);
    cmp_rd   = merge(compare, dm_wdata, dm_wen);
    led_mrg  = merge({16'h0000, led}, dm_wdata, dm_wen);
    mmio_rd  = off == OFF_COUNT   ? cnt_rd :
               off == OFF_COMPARE ? cmp_rd :
               off == OFF_STATUS  ? {31'd0, pending} : {16'h0000, led_mrg[15:0]};
    rdata_d  = ram_hit ? ram_rd : mmio_hit ? mmio_rd : 32'd0;
    bad_d    = unmapped && (|dm_wen || (prev_unmapped && prev_addr == dm_addr[31:2]));
  end
  // byte-lane RAM writes; contents survive reset
  always_ff @(posedge clk)
    if (ram_hit)
      for (int i = 0; i < 4; i++)
        if (dm_wen[i]) mem[word][8*i+:8] <= dm_wdata[8*i+:8];
  // read data, LED register and held-address tracking for the unmapped pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dm_rdata      <= '0;
      led           <= '0;
      bad_access    <= 1'b0;
      prev_addr     <= '0;
      prev_unmapped <= 1'b0;
    end else begin
      dm_rdata      <= rdata_d;
      led           <= (mmio_hit && off == OFF_LED) ? led_mrg[15:0] : led;
      bad_access    <= bad_d;
      prev_addr     <= dm_addr[31:2];
      prev_unmapped <= unmapped;
    end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed scoreboard bench for dm_responder
module tb_dm_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dm_addr = '0;
  logic [3:0]  dm_wen = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic [15:0] led;
  logic        timer_irq, bad_access;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic        crd;
    logic [31:0] rd;
    logic        cbad;
    logic        bad;
  } exp_t;
  exp_t sb[$];

  localparam logic [31:0] A_COUNT = 32'hBFD0_0000;
  localparam logic [31:0] A_CMP   = 32'hBFD0_0004;
  localparam logic [31:0] A_STAT  = 32'hBFD0_0008;
  localparam logic [31:0] A_LED   = 32'hBFD0_000C;
  localparam logic [31:0] A_BAD   = 32'h8000_0000;

  dm_responder dut (
    .clk        (clk),
    .reset      (reset),
    .dm_addr    (dm_addr),
    .dm_wen     (dm_wen),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .led        (led),
    .timer_irq  (timer_irq),
    .bad_access (bad_access)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d, input string tag,
                     input logic crd, input logic [31:0] erd, input logic cbad, input logic ebad);
    exp_t e;
    sb.push_back('{tag, crd, erd, cbad, ebad});
    dm_addr = a; dm_wen = w; dm_wdata = d;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.crd) chk({e.tag, "_rdata"}, dm_rdata, e.rd);
    if (e.cbad) chk({e.tag, "_bad"}, {31'd0, bad_access}, {31'd0, e.bad});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(32'h10, 4'h0, 32'h0, "idle", 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #3;
    chk("por_rdata", dm_rdata, 32'h0);
    chk("por_led", {16'h0, led}, 32'h0);
    chk("por_irq_bad", {30'd0, timer_irq, bad_access}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    // reset mid-operation
    cyc(A_LED, 4'hF, 32'h0000_00FF, "led_ff", 1'b1, 32'h0000_00FF, 1'b1, 1'b0);
    cyc(A_COUNT, 4'hF, 32'h0000_1234, "cnt_1234", 1'b1, 32'h0000_1234, 1'b1, 1'b0);
    chk("led_pre_rst", {16'h0, led}, 32'h0000_00FF);
    #2 reset = 1'b1;
    #1;
    chk("rst_rdata", dm_rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_irq_bad", {30'd0, timer_irq, bad_access}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    cyc(A_COUNT, 4'h0, 32'h0, "cnt_after_rst0", 1'b1, 32'h0, 1'b1, 1'b0);
    cyc(A_COUNT, 4'h0, 32'h0, "cnt_after_rst1", 1'b1, 32'h1, 1'b1, 1'b0);
    // byte writes and write-first reads
    cyc(32'h10, 4'hF, 32'hAABB_CCDD, "w10_full", 1'b1, 32'hAABB_CCDD, 1'b1, 1'b0);
    cyc(32'h10, 4'h1, 32'h0000_0011, "w10_lane0", 1'b1, 32'hAABB_CC11, 1'b1, 1'b0);
    cyc(32'h10, 4'h0, 32'h0, "r10", 1'b1, 32'hAABB_CC11, 1'b1, 1'b0);
    cyc(32'h20, 4'hF, 32'h0102_0304, "w20_full", 1'b1, 32'h0102_0304, 1'b0, 1'b0);
    cyc(32'h20, 4'hC, 32'h5566_0000, "w20_wf", 1'b1, 32'h5566_0304, 1'b0, 1'b0);
    cyc(32'h20, 4'h0, 32'h0, "r20", 1'b1, 32'h5566_0304, 1'b0, 1'b0);
    cyc(32'hFFC, 4'hF, 32'hCAFE_F00D, "wtop", 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
    cyc(32'hFFC, 4'h0, 32'h0, "rtop", 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
    cyc(32'h1000, 4'h0, 32'h0, "past_ram", 1'b1, 32'h0, 1'b1, 1'b0);
    cyc(32'h10, 4'h0, 32'h0, "after_past_ram", 1'b1, 32'hAABB_CC11, 1'b1, 1'b0);
    // timer compare, W1C and set-beats-clear
    cyc(A_CMP, 4'hF, 32'h5, "cmp5", 1'b1, 32'h5, 1'b0, 1'b0);
    cyc(A_COUNT, 4'hF, 32'h0, "cnt0", 1'b1, 32'h0, 1'b0, 1'b0);
    idle(5);
    chk("irq_before_match", {31'd0, timer_irq}, 32'h0);
    idle(1);
    chk("irq_on_match", {31'd0, timer_irq}, 32'h1);
    cyc(A_STAT, 4'h0, 32'h0, "stat_pend", 1'b1, 32'h1, 1'b0, 1'b0);
    idle(3);
    chk("irq_sticky", {31'd0, timer_irq}, 32'h1);
    cyc(A_STAT, 4'h1, 32'h1, "w1c", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("irq_cleared", {31'd0, timer_irq}, 32'h0);
    cyc(A_COUNT, 4'hF, 32'h3, "cnt3", 1'b1, 32'h3, 1'b0, 1'b0);
    idle(2);
    chk("irq_pre_race", {31'd0, timer_irq}, 32'h0);
    cyc(A_STAT, 4'h1, 32'h1, "w1c_race", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("irq_set_wins", {31'd0, timer_irq}, 32'h1);
    cyc(A_STAT, 4'h0, 32'h0, "stat_after_race", 1'b1, 32'h1, 1'b0, 1'b0);
    cyc(A_STAT, 4'h1, 32'h1, "w1c_final", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("irq_final_clear", {31'd0, timer_irq}, 32'h0);
    // LED register
    cyc(A_LED, 4'hF, 32'hDEAD_BEEF, "led_w", 1'b1, 32'h0000_BEEF, 1'b1, 1'b0);
    chk("led_out", {16'h0, led}, 32'h0000_BEEF);
    cyc(A_LED, 4'h0, 32'h0, "led_r", 1'b1, 32'h0000_BEEF, 1'b1, 1'b0);
    // unmapped accesses
    cyc(A_BAD, 4'h0, 32'h0, "bad_hold1", 1'b1, 32'h0, 1'b1, 1'b0);
    cyc(A_BAD, 4'h0, 32'h0, "bad_hold2", 1'b1, 32'h0, 1'b1, 1'b1);
    cyc(32'h10, 4'h0, 32'h0, "bad_hold_end", 1'b1, 32'hAABB_CC11, 1'b1, 1'b0);
    cyc(A_BAD, 4'h0, 32'h0, "bad_single", 1'b1, 32'h0, 1'b1, 1'b0);
    cyc(32'h10, 4'h0, 32'h0, "bad_single_end", 1'b1, 32'hAABB_CC11, 1'b1, 1'b0);
    cyc(32'h8000_0010, 4'hF, 32'h1234_5678, "bad_write", 1'b1, 32'h0, 1'b1, 1'b1);
    cyc(32'h10, 4'h0, 32'h0, "ram_untouched", 1'b1, 32'hAABB_CC11, 1'b1, 1'b0);
    cyc(32'hBFD0_0010, 4'hF, 32'hFFFF_FFFF, "mmio_hole_w", 1'b1, 32'h0, 1'b1, 1'b1);
    cyc(A_LED, 4'h0, 32'h0, "led_untouched", 1'b1, 32'h0000_BEEF, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
